// File: rtl/timer_sched_ctrl.sv
// timer_sched_ctrl: Avalon-MM master sequencing a 16-bit interval timer (IRQ ack, configuration, snapshot)
//   clk, reset_n                  : clock, async active-low reset
//   cfg_valid/ready/period/cont/ito : configuration handshake and 32-bit period
//   snap_req/valid/value          : counter snapshot request and 32-bit result
//   tick, tick_count, busy        : acknowledged-timeout pulse/count, sequence in progress
//   tmr_*                         : registered timer slave bus and level IRQ input
module timer_sched_ctrl #(
  parameter int TICK_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_cont,
  input  logic              cfg_ito,
  input  logic              snap_req,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              busy,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq
);
  typedef enum logic [3:0] {
    IDLE, CFG_STOP, CFG_PL, CFG_PH, CFG_CLR, CFG_CTL,
    ACK_CLR, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP
  } state_t;
  state_t      state, nxt;
  logic [31:0] per_q;
  logic        cont_q, ito_q;
  logic        n_cs, n_wn;
  logic [2:0]  n_addr;
  logic [15:0] n_wd;
  assign busy      = state != IDLE;
  assign cfg_ready = state == IDLE && !tmr_irq;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = tmr_irq ? ACK_CLR : cfg_valid ? CFG_STOP : snap_req ? SNAP_WR : IDLE;
      CFG_STOP: nxt = CFG_PL;
      CFG_PL:   nxt = CFG_PH;
      CFG_PH:   nxt = CFG_CLR;
      CFG_CLR:  nxt = CFG_CTL;
      SNAP_WR:  nxt = SNAP_RL;
      SNAP_RL:  nxt = SNAP_RH;
      SNAP_RH:  nxt = SNAP_CAP;
      default:  nxt = IDLE;
    endcase
  end
  // Bus outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    n_cs   = nxt != IDLE && nxt != SNAP_CAP;
    n_wn   = !n_cs || nxt == SNAP_RL || nxt == SNAP_RH;
    n_addr = '0;
    n_wd   = '0;
    case (nxt)
      CFG_STOP:         {n_addr, n_wd} = {3'd1, 16'h0008};
      CFG_PL:           {n_addr, n_wd} = {3'd2, per_q[15:0]};
      CFG_PH:           {n_addr, n_wd} = {3'd3, per_q[31:16]};
      CFG_CTL:          {n_addr, n_wd} = {3'd1, 12'h000, 2'b01, cont_q, ito_q};
      SNAP_WR, SNAP_RL: n_addr = 3'd4;
      SNAP_RH:          n_addr = 3'd5;
      default:          ;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      per_q          <= '0;
      cont_q         <= 1'b0;
      ito_q          <= 1'b0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
      snap_valid     <= 1'b0;
      snap_value     <= '0;
      tick           <= 1'b0;
      tick_count     <= '0;
    end else begin
      state          <= nxt;
      tmr_chipselect <= n_cs;
      tmr_write_n    <= n_wn;
      tmr_address    <= n_addr;
      tmr_writedata  <= n_wd;
      tick           <= nxt == ACK_CLR;
      snap_valid     <= state == SNAP_CAP;
      if (state == IDLE && nxt == CFG_STOP) {per_q, cont_q, ito_q} <= {cfg_period, cfg_cont, cfg_ito};
      if (nxt == ACK_CLR) tick_count <= tick_count + TICK_W'(1);
      if (nxt == CFG_CTL) tick_count <= '0;
      // Timer read data arrives one cycle after its address: low half during SNAP_RH, high half during SNAP_CAP.
      if (state == SNAP_RH) snap_value[15:0] <= tmr_readdata;
      if (state == SNAP_CAP) snap_value[31:16] <= tmr_readdata;
    end
  end
endmodule

// File: tb/tb_timer_sched_ctrl.sv
// tb_timer_sched_ctrl: directed self-checking bench with timer slave model and expected-transaction scoreboard
module tb_timer_sched_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_valid, cfg_cont, cfg_ito, snap_req;
  logic [31:0] cfg_period;
  logic        cfg_ready, snap_valid, tick, busy;
  logic [31:0] snap_value, tick_count;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata, tmr_readdata;
  logic        tmr_irq;
  logic        cfg_ready4, snap_valid4, tick4, busy4;
  logic [31:0] snap_value4;
  logic [3:0]  tc4;
  logic [2:0]  tmr_address4;
  logic        tmr_chipselect4, tmr_write_n4;
  logic [15:0] tmr_writedata4;
  int          asserts = 0, fails = 0;
  int          raise_cnt = 0, clr_cnt = 0;
  logic [31:0] tmr_counter = '0, snap_lat = '0;
  logic [31:0] snap_exp = 32'h1234_5678;
  int          cnt = 0, snap_cd = 0;
  typedef struct {
    logic [2:0]  a;
    logic        w;
    logic [15:0] d;
    logic        tk;
    logic        clr;
  } ent_t;
  ent_t q[$];
  always #5 clk = ~clk;
  assign tmr_irq = raise_cnt != clr_cnt;
  timer_sched_ctrl #(.TICK_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_cont(cfg_cont), .cfg_ito(cfg_ito), .snap_req(snap_req),
    .snap_valid(snap_valid), .snap_value(snap_value), .tick(tick), .tick_count(tick_count),
    .busy(busy), .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata),
    .tmr_irq(tmr_irq)
  );
  timer_sched_ctrl #(.TICK_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4),
    .cfg_period(cfg_period), .cfg_cont(cfg_cont), .cfg_ito(cfg_ito), .snap_req(snap_req),
    .snap_valid(snap_valid4), .snap_value(snap_value4), .tick(tick4), .tick_count(tc4),
    .busy(busy4), .tmr_address(tmr_address4), .tmr_chipselect(tmr_chipselect4),
    .tmr_write_n(tmr_write_n4), .tmr_writedata(tmr_writedata4), .tmr_readdata(tmr_readdata),
    .tmr_irq(tmr_irq)
  );
  // Timer slave: registered read data, snapshot latch on write to 4, status write clears the IRQ.
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n)
      tmr_readdata <= tmr_address == 3'd4 ? snap_lat[15:0] : tmr_address == 3'd5 ? snap_lat[31:16] : 16'h0;
    if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd4) snap_lat <= tmr_counter;
    if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0 && tmr_irq) clr_cnt <= raise_cnt;
  end
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction
  function automatic void exp_op(logic [2:0] a, logic w, logic [15:0] d, logic tk, logic clr);
    ent_t e;
    e.a = a; e.w = w; e.d = d; e.tk = tk; e.clr = clr;
    q.push_back(e);
  endfunction
  function automatic void exp_cfg(logic [31:0] p, logic c, logic i);
    exp_op(3'd1, 1'b1, 16'h0008, 1'b0, 1'b0);
    exp_op(3'd2, 1'b1, p[15:0], 1'b0, 1'b0);
    exp_op(3'd3, 1'b1, p[31:16], 1'b0, 1'b0);
    exp_op(3'd0, 1'b1, 16'h0000, 1'b0, 1'b0);
    exp_op(3'd1, 1'b1, {12'h000, 2'b01, c, i}, 1'b0, 1'b1);
  endfunction
  always @(negedge clk) begin
    ent_t e;
    logic esv;
    if (!reset_n) begin
      q.delete();
      cnt = 0;
      snap_cd = 0;
    end else begin
      e.a = '0; e.w = 1'b0; e.d = '0; e.tk = 1'b0; e.clr = 1'b0;
      esv = snap_cd == 1;
      if (snap_cd > 0) snap_cd--;
      if (tmr_chipselect) begin
        asserts++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL bus_unexpected: got access addr %0d write_n %b, required none", tmr_address, tmr_write_n);
        end else begin
          e = q.pop_front();
          chk("bus_addr", 32'(tmr_address), 32'(e.a));
          chk("bus_is_write", 32'(!tmr_write_n), 32'(e.w));
          if (e.w) chk("bus_wdata", 32'(tmr_writedata), 32'(e.d));
          if (!e.w && e.a == 3'd5) snap_cd = 2;
        end
      end else chk("bus_idle_write_n", 32'(tmr_write_n), 32'd1);
      if (e.tk) cnt++;
      if (e.clr) cnt = 0;
      chk("tick", 32'(tick), 32'(e.tk));
      chk("tick4", 32'(tick4), 32'(e.tk));
      chk("tick_count", tick_count, 32'(cnt));
      chk("tick_count4", 32'(tc4), 32'(cnt[3:0]));
      chk("snap_valid", 32'(snap_valid), 32'(esv));
      if (esv) chk("snap_value", snap_value, snap_exp);
    end
  end
  task automatic send_cfg(logic [31:0] p, logic c, logic i);
    int n = 0;
    cfg_period = p; cfg_cont = c; cfg_ito = i; cfg_valid = 1'b1;
    while (!cfg_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("cfg_accept_in_time", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin @(posedge clk); #1; n++; end
    chk("idle_in_time", 32'(n < 50), 32'd1);
  endtask
  task automatic do_ack();
    exp_op(3'd0, 1'b1, 16'h0000, 1'b1, 1'b0);
    raise_cnt++;
    @(posedge clk); #1;
    chk("ack_tick_pulse", 32'(tick), 32'd1);
    @(posedge clk); #1;
    chk("ack_irq_cleared", 32'(tmr_irq), 32'd0);
    chk("ack_back_idle", 32'(busy), 32'd0);
  endtask
  task automatic chk_reset_vals();
    chk("rst_chipselect", 32'(tmr_chipselect), 32'd0);
    chk("rst_write_n", 32'(tmr_write_n), 32'd1);
    chk("rst_address", 32'(tmr_address), 32'd0);
    chk("rst_writedata", 32'(tmr_writedata), 32'd0);
    chk("rst_snap_valid", 32'(snap_valid), 32'd0);
    chk("rst_snap_value", snap_value, 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_tick_count", tick_count, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, k;
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_cont = 1'b0; cfg_ito = 1'b0; snap_req = 1'b0; cfg_period = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    // Configuration with hand-computed bus writes
    exp_op(3'd1, 1'b1, 16'h0008, 1'b0, 1'b0);
    exp_op(3'd2, 1'b1, 16'h86A0, 1'b0, 1'b0);
    exp_op(3'd3, 1'b1, 16'h0001, 1'b0, 1'b0);
    exp_op(3'd0, 1'b1, 16'h0000, 1'b0, 1'b0);
    exp_op(3'd1, 1'b1, 16'h0007, 1'b0, 1'b1);
    send_cfg(32'h0001_86A0, 1'b1, 1'b1);
    chk("cfg_ready_low_busy", 32'(cfg_ready), 32'd0);
    wait_idle(n);
    chk("cfg_busy_cycles", 32'(n), 32'd5);
    chk("cfg_tick_count_zero", tick_count, 32'd0);
    chk("cfg_ready_after", 32'(cfg_ready), 32'd1);
    // Four IRQ acknowledges
    repeat (4) do_ack();
    chk("four_acks_count", tick_count, 32'd4);
    chk("four_acks_count4", 32'(tc4), 32'd4);
    // IRQ and configuration in the same IDLE cycle: ACK wins
    exp_op(3'd0, 1'b1, 16'h0000, 1'b1, 1'b0);
    exp_cfg(32'hDEAD_BEEF, 1'b0, 1'b1);
    cfg_period = 32'hDEAD_BEEF; cfg_cont = 1'b0; cfg_ito = 1'b1; cfg_valid = 1'b1;
    raise_cnt++;
    #1 chk("prio_ready_low", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    chk("prio_ack_first", 32'(tick), 32'd1);
    chk("prio_ready_low_ack", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    chk("prio_ready_after_ack", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    chk("prio_cfg_stop_addr", 32'(tmr_address), 32'd1);
    cfg_valid = 1'b0;
    wait_idle(n);
    chk("prio_cfg_cleared_count", tick_count, 32'd0);
    // Snapshot
    tmr_counter = 32'h1234_5678;
    exp_op(3'd4, 1'b1, 16'h0000, 1'b0, 1'b0);
    exp_op(3'd4, 1'b0, 16'h0000, 1'b0, 1'b0);
    exp_op(3'd5, 1'b0, 16'h0000, 1'b0, 1'b0);
    snap_req = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
    k = 0;
    while (!snap_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk("snap_latency", 32'(k), 32'd4);
    chk("snap_value_lit", snap_value, 32'h1234_5678);
    @(posedge clk); #1;
    chk("snap_valid_one_cycle", 32'(snap_valid), 32'd0);
    // 4-bit counter wrap
    repeat (15) do_ack();
    chk("wrap_count4_15", 32'(tc4), 32'd15);
    do_ack();
    chk("wrap_count4_0", 32'(tc4), 32'd0);
    chk("wrap_count32_16", tick_count, 32'd16);
    // Reset in the middle of CFG_PH
    exp_cfg(32'h0000_0010, 1'b1, 1'b0);
    send_cfg(32'h0000_0010, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midcfg_in_ph", 32'(tmr_address), 32'd3);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals();
    @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_bus_idle", 32'(tmr_chipselect), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/timer_sched_ctrl.md
Name: timer_sched_ctrl

Overview:
- Avalon-MM master that sequences the 16-bit-register interval timer peripheral: programs the period and mode, acknowledges timeout IRQs, and takes counter snapshots.
- Arbitrates three requesters onto the timer's single slave port: IRQ acknowledge, configuration, and snapshot.
- Sits between the system tick logic and the timer slave. Presents a 32-bit period / tick-count interface so software and hardware clients never touch the timer registers directly.

Parameters:
- TICK_W, 32, width of the accumulated tick counter (1..32).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  high only in IDLE with no IRQ pending; handshake completes when cfg_valid & cfg_ready
- cfg_period  in  32  timer period value (loaded as-is; counter counts period..0)
- cfg_cont  in  1  continuous mode
- cfg_ito  in  1  interrupt enable
- snap_req  in  1  snapshot request (level; accepted in IDLE)
- snap_valid  out  1  one-cycle pulse, snap_value valid
- snap_value  out  32  captured counter value
- tick  out  1  one-cycle pulse per acknowledged timeout
- tick_count  out  TICK_W  acknowledged timeouts since last configuration
- busy  out  1  FSM not in IDLE
- tmr_address  out  3  timer slave address
- tmr_chipselect  out  1  timer chipselect
- tmr_write_n  out  1  timer write strobe, active-low
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data (timer registers it: valid the cycle after the address is presented)
- tmr_irq  in  1  timer interrupt, level; stays high until a status write

Behaviour:
- Reset (async, reset_n=0): state IDLE, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, snap_valid=0, snap_value=0, tick=0, tick_count=0, busy=0. Reset mid-sequence abandons it; partially written timer registers are not restored.
- All tmr_* outputs are registered. One bus access per state/cycle. Timer has no waitrequest, so every access completes in its cycle.
- Arbitration in IDLE, fixed priority: tmr_irq > cfg_valid > snap_req. cfg_ready = (state==IDLE) & ~tmr_irq. On acceptance, cfg_period/cont/ito are latched.
- CFG sequence, one write per cycle, addr:data:
  - CFG_STOP 1:0x0008
  - CFG_PL 2:period[15:0]
  - CFG_PH 3:period[31:16]
  - CFG_CLR 0:0x0000
  - CFG_CTL 1:{12'b0,0,1,cont,ito}
  - Then IDLE.
  - tick_count cleared to 0 in CFG_CTL.
  - Total: 5 bus cycles, busy for 5 cycles.
- ACK sequence, entered when tmr_irq=1 in IDLE:
  - ACK_CLR writes 0:0x0000.
  - tick pulses in the same cycle; tick_count increments, wrapping modulo 2^TICK_W.
  - Return to IDLE. The timer IRQ drops by the next cycle, so no double-ack.
- SNAP sequence:
  - SNAP_WR: write 4:0x0000, latches the counter.
  - SNAP_RL: read 4.
  - SNAP_RH: read 5; capture tmr_readdata into snap_value[15:0].
  - SNAP_CAP: bus idle; capture tmr_readdata into snap_value[31:16]; snap_valid=1.
  - Then IDLE.
  - Read cycles: chipselect=1, write_n=1.
- An IRQ arriving mid-sequence waits until IDLE; a sequence is never preempted.
- Bus idle (chipselect=0, write_n=1) in IDLE and SNAP_CAP.

Test Plan:
- Reset, then cfg_valid with period=0x0001_86A0, cont=1, ito=1 -> writes 1:0008, 2:86A0, 3:0001, 0:0000, 1:0007 on consecutive cycles; cfg_ready low for 5 cycles; tick_count=0.
- Drive tmr_irq high (level, held until the status write) -> exactly one write 0:0000, one tick pulse, tick_count 0→1. Repeat 3 times -> tick_count=4.
- tmr_irq and cfg_valid asserted in the same IDLE cycle -> ACK runs first and cfg_ready stays low; CFG starts the cycle after ACK_CLR.
- snap_req with a timer model whose counter = 0x1234_5678 at the snap write -> bus sequence W4, R4, R5; snap_valid pulses 4 cycles after acceptance with snap_value=0x1234_5678.
- TICK_W=4, 16 IRQ acks -> tick_count wraps 15→0.
- Assert reset_n=0 during CFG_PH -> all outputs go to reset values immediately; after release, IDLE with cfg_ready=1.
